// File: rtl/keypad_encoder.sv
// 4x3 keypad scanner with press/release debounce.
// Emits BCD digit + load, or start ('#') / clear ('*') pulses.
module keypad_encoder #(
  parameter int DWELL    = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [2:0] cols,
  output logic [3:0] digit,
  output logic       load,
  output logic       start,
  output logic       clear
);

  localparam logic [1:0] ST_SCAN = 2'd0;
  localparam logic [1:0] ST_DEB  = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_WREL = 2'd3;

  localparam int DW = $clog2(DWELL + 1);
  localparam int SW = $clog2(DEBOUNCE + 1);

  logic [1:0]    state;
  logic [3:0]    sync_q;
  logic [3:0]    rows_s;
  logic [3:0]    row_q;
  logic [DW-1:0] dwell_cnt;
  logic [SW-1:0] stab_cnt;

  logic       one_hot;
  logic [1:0] ridx;
  logic [1:0] cidx;
  logic [3:0] code;
  logic       is_num;
  logic       is_star;
  logic       is_hash;

  assign one_hot = (rows_s != 4'd0)
                && ((rows_s & (rows_s - 4'd1)) == 4'd0);

  always_comb begin
    ridx = 2'd0;
    unique case (1'b1)
      row_q[0]: ridx = 2'd0;
      row_q[1]: ridx = 2'd1;
      row_q[2]: ridx = 2'd2;
      row_q[3]: ridx = 2'd3;
      default:  ridx = 2'd0;
    endcase
  end

  always_comb begin
    cidx = 2'd0;
    unique case (1'b1)
      cols[0]: cidx = 2'd0;
      cols[1]: cidx = 2'd1;
      cols[2]: cidx = 2'd2;
      default: cidx = 2'd0;
    endcase
  end

  // Rows 0-2 are 1..9 in reading order; bottom row is *, 0, #.
  always_comb begin
    code    = 4'd0;
    is_num  = 1'b0;
    is_star = 1'b0;
    is_hash = 1'b0;
    if (ridx != 2'd3) begin
      code   = 4'(ridx) * 4'd3 + 4'(cidx) + 4'd1;
      is_num = 1'b1;
    end else begin
      unique case (cidx)
        2'd0:    is_star = 1'b1;
        2'd1:    is_num  = 1'b1;
        default: is_hash = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SCAN;
      sync_q    <= 4'd0;
      rows_s    <= 4'd0;
      row_q     <= 4'd0;
      cols      <= 3'b001;
      dwell_cnt <= '0;
      stab_cnt  <= '0;
      digit     <= 4'd0;
      load      <= 1'b0;
      start     <= 1'b0;
      clear     <= 1'b0;
    end else begin
      sync_q <= rows;
      rows_s <= sync_q;
      load   <= 1'b0;
      start  <= 1'b0;
      clear  <= 1'b0;
      unique case (state)
        ST_SCAN: begin
          if (dwell_cnt == DW'(DWELL - 1)) begin
            dwell_cnt <= '0;
            if (rows_s == 4'd0) begin
              cols <= {cols[1:0], cols[2]};
            end else if (one_hot) begin
              row_q    <= rows_s;
              stab_cnt <= '0;
              state    <= ST_DEB;
            end else begin
              stab_cnt <= '0;
              state    <= ST_WREL;
            end
          end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
          end
        end
        ST_DEB: begin
          if (rows_s != row_q) begin
            dwell_cnt <= '0;
            state     <= ST_SCAN;
          end else if (stab_cnt == SW'(DEBOUNCE - 1)) begin
            stab_cnt <= SW'(DEBOUNCE);
            state    <= ST_EMIT;
            load     <= is_num;
            start    <= is_hash;
            clear    <= is_star;
            if (is_num) digit <= code;
          end else begin
            stab_cnt <= stab_cnt + SW'(1);
          end
        end
        ST_EMIT: begin
          stab_cnt <= '0;
          state    <= ST_WREL;
        end
        default: begin
          if (rows_s != 4'd0) begin
            stab_cnt <= '0;
          end else if (stab_cnt == SW'(DEBOUNCE - 1)) begin
            stab_cnt  <= '0;
            dwell_cnt <= '0;
            cols      <= 3'b001;
            state     <= ST_SCAN;
          end else begin
            stab_cnt <= stab_cnt + SW'(1);
          end
        end
      endcase
    end
  end

endmodule
